// File: rtl/somador_serial.sv
// somador_serial: bit-serial WIDTH-bit adder driving one full-adder cell per clock, LSB first.
// Define SOMADOR_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, sum, carry, last;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif
  assign sum   = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign last  = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      state_d = RUN;
      sa_d    = a;
      sb_d    = b;
      c_d     = cin;
      cnt_d   = '0;
      s_d     = '0;
      cout_d  = 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (state_q == RUN) begin
      s_d     = {sum, s_q[WIDTH-1:1]};
      sa_d    = sa_q >> 1;
      sb_d    = sb_q >> 1;
      c_d     = carry;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
      cout_d  = last ? carry : cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
      // carry into the MSB differs from carry out of it
      ovf_d   = last ? (c_q ^ carry) : ovf_q;
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign s    = s_q;
  assign cout = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: table vectors and corner sequences at WIDTH=8, random held-start sweeps at WIDTH=4 and 16.
module tb_somador_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic st8 = 1'b0, ci8 = 1'b0, busy8, done8, co8, ov8, pd8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic st4 = 1'b0, ci4 = 1'b0, busy4, done4, co4, ov4, pd4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic st16 = 1'b0, ci16 = 1'b0, busy16, done16, co16, ov16, pd16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;

  somador_serial #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .s(s8), .cout(co8)
`ifdef SOMADOR_SERIAL_OVF_EN
    , .ovf(ov8)
`endif
  );
  somador_serial #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(ci4),
    .busy(busy4), .done(done4), .s(s4), .cout(co4)
`ifdef SOMADOR_SERIAL_OVF_EN
    , .ovf(ov4)
`endif
  );
  somador_serial #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(ci16),
    .busy(busy16), .done(done16), .s(s16), .cout(co16)
`ifdef SOMADOR_SERIAL_OVF_EN
    , .ovf(ov16)
`endif
  );
`ifndef SOMADOR_SERIAL_OVF_EN
  assign ov8 = 1'b0;
  assign ov4 = 1'b0;
  assign ov16 = 1'b0;
`endif

  typedef struct {
    logic [16:0] sum;
    logic        ov;
    int          acc;
  } exp_t;
  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  exp_t q8[$], q4[$], q16[$];
  vec_t tv[8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", n, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string n);
    total++;
    bad++;
    $display("FAIL %s done with empty scoreboard cyc=%0d", n, cyc);
  endtask

  function automatic exp_t mk(input logic [15:0] x, input logic [15:0] y, input logic ci, input int w);
    mk.sum = 17'(x) + 17'(y) + 17'(ci);
    mk.ov  = (x[w-1] == y[w-1]) && (mk.sum[w-1] != x[w-1]);
    mk.acc = cyc + 1;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done8) begin
      chk("done8_width", 32'(pd8), 32'd0);
      if (q8.size() == 0) spurious("done8");
      else begin
        e = q8.pop_front();
        chk("sum8", 32'({co8, s8}), 32'(e.sum[8:0]));
        chk("lat8", cyc - e.acc, 32'd8);
`ifdef SOMADOR_SERIAL_OVF_EN
        chk("ovf8", 32'(ov8), 32'(e.ov));
`endif
      end
    end
    if (done4) begin
      chk("done4_width", 32'(pd4), 32'd0);
      if (q4.size() == 0) spurious("done4");
      else begin
        e = q4.pop_front();
        chk("sum4", 32'({co4, s4}), 32'(e.sum[4:0]));
        chk("lat4", cyc - e.acc, 32'd4);
`ifdef SOMADOR_SERIAL_OVF_EN
        chk("ovf4", 32'(ov4), 32'(e.ov));
`endif
      end
    end
    if (done16) begin
      chk("done16_width", 32'(pd16), 32'd0);
      if (q16.size() == 0) spurious("done16");
      else begin
        e = q16.pop_front();
        chk("sum16", 32'({co16, s16}), 32'(e.sum));
        chk("lat16", cyc - e.acc, 32'd16);
`ifdef SOMADOR_SERIAL_OVF_EN
        chk("ovf16", 32'(ov16), 32'(e.ov));
`endif
      end
    end
    pd8 = done8;
    pd4 = done4;
    pd16 = done16;
  endtask

  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic ci, input exp_t e);
    tick();
    a8 = x;
    b8 = y;
    ci8 = ci;
    st8 = 1'b1;
    q8.push_back(e);
    tick();
    st8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    ci8 = 1'($urandom);
    chk("busy8_run", 32'(busy8), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q8.size() + q4.size() + q16.size()) != 0; k++) tick();
    if ((q8.size() + q4.size() + q16.size()) != 0) begin
      chk("drain_timeout", q8.size() + q4.size() + q16.size(), 32'd0);
      q8.delete();
      q4.delete();
      q16.delete();
    end
    tick();
  endtask

  initial begin
    exp_t e;
    tv = '{
      '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0}
    };
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_s", 32'(s8), 32'd0);
    chk("rst_cout", 32'(co8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_ovf", 32'(ov8), 32'd0);
    for (int i = 0; i < 8; i++) begin
      e.sum = {8'b0, tv[i].co, tv[i].s};
      e.ov = tv[i].ov;
      e.acc = cyc + 2;
      start8(tv[i].a, tv[i].b, tv[i].ci, e);
      drain();
      chk("hold8", 32'({co8, s8}), 32'({tv[i].co, tv[i].s}));
    end
    // start held high with operands changing every cycle: only every 10th edge is accepted
    for (int i = 0; i < 40; i++) begin
      tick();
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ci8 = 1'($urandom);
      st8 = 1'b1;
      if (i % 10 == 0) q8.push_back(mk(16'(a8), 16'(b8), ci8, 8));
    end
    tick();
    st8 = 1'b0;
    drain();
    // reset at edge 4 of a run aborts it
    start8(8'hF0, 8'h0F, 1'b1, mk(16'hF0, 16'h0F, 1'b1, 8));
    repeat (3) tick();
    rst = 1'b1;
    q8.delete();
    tick();
    rst = 1'b0;
    chk("abort_s", 32'(s8), 32'd0);
    chk("abort_cout", 32'(co8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_ovf", 32'(ov8), 32'd0);
    repeat (12) tick();
    e.sum = 17'h3;
    e.ov = 1'b0;
    e.acc = cyc + 2;
    start8(8'h01, 8'h02, 1'b0, e);
    drain();
    // reset and start on the same edge: start is dropped
    tick();
    rst = 1'b1;
    st8 = 1'b1;
    a8 = 8'h11;
    b8 = 8'h22;
    tick();
    rst = 1'b0;
    st8 = 1'b0;
    chk("rst_start_busy", 32'(busy8), 32'd0);
    repeat (12) tick();
    chk("rst_start_s", 32'(s8), 32'd0);
    // random held-start sweeps; accepted every WIDTH+2 edges
    for (int i = 0; i < 3600; i++) begin
      tick();
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      ci4 = 1'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ci16 = 1'($urandom);
      st4 = 1'b1;
      st16 = 1'b1;
      if (i % 6 == 0) q4.push_back(mk(16'(a4), 16'(b4), ci4, 4));
      if (i % 18 == 0) q16.push_back(mk(a16, b16, ci16, 16));
    end
    tick();
    st4 = 1'b0;
    st16 = 1'b0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
